wave_gen_poly: RTL and testbench

- Next-generation oscillator: NUM_VOICES independent voices, each with its own phase accumulator, increment, wave type and pulse width.
- One shared two-stage shaping pipeline, time-multiplexed round-robin across voices, one voice slot per enabled clock.
- Emits a tagged per-voice sample stream plus a summed mix once per frame.
- Sits between the note/control logic (config writes) and the mixer/DAC path.

---
 rtl/wave_gen_pkg.sv | 25 ++
 rtl/wave_shaper.sv | 27 ++
 rtl/wave_gen_poly.sv | 153 +++++++++++++++
 tb/tb_wave_gen_poly.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
// Shared types and helpers for the polyphonic wave generator.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'b00,
        WAVE_SQUARE = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_NOISE  = 2'b11
    } wave_type_e;

    localparam int unsigned LFSR_EXTRA_BITS = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Reset pulse width: half scale, i.e. 50% duty square.
    function automatic int unsigned default_pw(input int unsigned depth);
        return 32'(1) << (depth - 1);
    endfunction

endpackage

// File: rtl/wave_shaper.sv
// Combinational stage-1 shaping: maps truncated phase t to a sample for the selected wave type.
module wave_shaper
    import wave_gen_pkg::*;
#(
    parameter int unsigned WAVE_DEPTH = 8
)(
    input  logic [WAVE_DEPTH-1:0] t,
    input  logic [1:0]            wave_type,
    input  logic [WAVE_DEPTH-1:0] pulse_width,
    input  logic [WAVE_DEPTH-1:0] noise,
    output logic [WAVE_DEPTH-1:0] sample_c
);

    logic [WAVE_DEPTH-1:0] tri_u_c;

    always_comb begin
        tri_u_c  = {t[WAVE_DEPTH-2:0], 1'b0};
        sample_c = '0;
        case (wave_type_e'(wave_type))
            WAVE_SAW:    sample_c = t;
            WAVE_SQUARE: sample_c = (t < pulse_width) ? '1 : '0;
            WAVE_TRI:    sample_c = t[WAVE_DEPTH-1] ? ~tri_u_c : tri_u_c;
            WAVE_NOISE:  sample_c = noise;
        endcase
    end

endmodule

// File: rtl/wave_gen_poly.sv
// Polyphonic oscillator: per-voice phase accumulators sharing one round-robin two-stage shaping pipeline.
// Define WAVE_GEN_POLY_NOISE_EN to give each voice a Galois LFSR noise source for wave type 11.
module wave_gen_poly
    import wave_gen_pkg::*;
#(
    parameter  int unsigned WAVE_DEPTH  = 8,
    parameter  int unsigned PHASE_WIDTH = 16,
    parameter  int unsigned NUM_VOICES  = 4,
    localparam int unsigned VOICE_BITS  = clog2(NUM_VOICES)
)(
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             Enable,
    input  logic                             CfgWrite,
    input  logic [VOICE_BITS-1:0]            CfgVoice,
    input  logic [PHASE_WIDTH-1:0]           CfgIncr,
    input  logic [1:0]                       CfgWaveType,
    input  logic [WAVE_DEPTH-1:0]            CfgPulseWidth,
    input  logic                             CfgPhaseReset,
    output logic                             SampleValid,
    output logic [VOICE_BITS-1:0]            SampleVoice,
    output logic [WAVE_DEPTH-1:0]            Sample,
    output logic                             MixValid,
    output logic [WAVE_DEPTH+VOICE_BITS-1:0] MixOut
);

    localparam int unsigned           MIX_WIDTH  = WAVE_DEPTH + VOICE_BITS;
    localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(NUM_VOICES - 1);
    localparam logic [WAVE_DEPTH-1:0] PW_RESET   = WAVE_DEPTH'(default_pw(WAVE_DEPTH));

    logic [PHASE_WIDTH-1:0] phase       [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] incr        [NUM_VOICES];
    logic [1:0]             wave_type   [NUM_VOICES];
    logic [WAVE_DEPTH-1:0]  pulse_width [NUM_VOICES];
    logic [VOICE_BITS-1:0]  slot;

    logic                  s0_valid;
    logic [VOICE_BITS-1:0] s0_voice;
    logic [WAVE_DEPTH-1:0] s0_t;
    logic [1:0]            s0_type;
    logic [WAVE_DEPTH-1:0] s0_pw;
    logic [WAVE_DEPTH-1:0] s0_noise;

    logic [WAVE_DEPTH-1:0] noise_sel_c;
    logic [WAVE_DEPTH-1:0] shaped_c;
    logic [MIX_WIDTH-1:0]  mix_acc;
    logic [MIX_WIDTH-1:0]  mix_sum_c;

`ifdef WAVE_GEN_POLY_NOISE_EN
    localparam int unsigned           LFSR_WIDTH = WAVE_DEPTH + LFSR_EXTRA_BITS;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = LFSR_WIDTH'(16'hB400);

    logic [LFSR_WIDTH-1:0] lfsr   [NUM_VOICES];
    logic                  wrap_c [NUM_VOICES];

    always_comb begin
        for (int unsigned v = 0; v < NUM_VOICES; v++)
            wrap_c[v] = PHASE_WIDTH'(phase[v] + incr[v]) < phase[v];
        noise_sel_c = lfsr[slot][LFSR_WIDTH-1 -: WAVE_DEPTH];
    end

    // Each LFSR steps only on its own slot when that voice's phase wraps.
    always_ff @(posedge Clock) begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (Reset)
                lfsr[v] <= LFSR_WIDTH'(1);
            else if (Enable && slot == VOICE_BITS'(v) && wrap_c[v])
                lfsr[v] <= (lfsr[v] >> 1) ^ (lfsr[v][0] ? LFSR_TAPS : '0);
        end
    end
`else
    assign noise_sel_c = '0;
`endif

    // Slot issue, stage 0 capture, phase accumulate and config writes; a same-cycle write wins over accumulate.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            slot     <= '0;
            s0_valid <= 1'b0;
            s0_voice <= '0;
            s0_t     <= '0;
            s0_type  <= WAVE_SAW;
            s0_pw    <= PW_RESET;
            s0_noise <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                phase[v]       <= '0;
                incr[v]        <= '0;
                wave_type[v]   <= WAVE_SAW;
                pulse_width[v] <= PW_RESET;
            end
        end else begin
            s0_valid <= Enable;
            if (Enable) begin
                s0_voice <= slot;
                s0_t     <= phase[slot][PHASE_WIDTH-1 -: WAVE_DEPTH];
                s0_type  <= wave_type[slot];
                s0_pw    <= pulse_width[slot];
                s0_noise <= noise_sel_c;
                slot     <= (slot == LAST_VOICE) ? '0 : slot + VOICE_BITS'(1);
            end
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (Enable && slot == VOICE_BITS'(v))
                    phase[v] <= phase[v] + incr[v];
                if (CfgWrite && CfgVoice == VOICE_BITS'(v)) begin
                    incr[v]        <= CfgIncr;
                    wave_type[v]   <= CfgWaveType;
                    pulse_width[v] <= CfgPulseWidth;
                    if (CfgPhaseReset)
                        phase[v] <= '0;
                end
            end
        end
    end

    wave_shaper #(.WAVE_DEPTH(WAVE_DEPTH)) u_shaper (
        .t           (s0_t),
        .wave_type   (s0_type),
        .pulse_width (s0_pw),
        .noise       (s0_noise),
        .sample_c    (shaped_c)
    );

    // Voice 0 restarts the frame sum.
    always_comb begin
        mix_sum_c = MIX_WIDTH'(shaped_c);
        if (s0_voice != '0)
            mix_sum_c = mix_acc + MIX_WIDTH'(shaped_c);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            SampleValid <= 1'b0;
            SampleVoice <= '0;
            Sample      <= '0;
            mix_acc     <= '0;
            MixValid    <= 1'b0;
            MixOut      <= '0;
        end else begin
            SampleValid <= s0_valid;
            MixValid    <= 1'b0;
            if (s0_valid) begin
                SampleVoice <= s0_voice;
                Sample      <= shaped_c;
                mix_acc     <= mix_sum_c;
                if (s0_voice == LAST_VOICE) begin
                    MixOut   <= mix_sum_c;
                    MixValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_gen_poly.sv
// Directed self-checking bench for wave_gen_poly at default parameters (8/16/4).
module tb_wave_gen_poly;

    localparam int unsigned WD = 8;
    localparam int unsigned PW = 16;
    localparam int unsigned NV = 4;
    localparam int unsigned VB = 2;

    logic          Clock = 1'b0;
    logic          Reset, Enable, CfgWrite, CfgPhaseReset;
    logic [VB-1:0] CfgVoice;
    logic [PW-1:0] CfgIncr;
    logic [1:0]    CfgWaveType;
    logic [WD-1:0] CfgPulseWidth;
    logic          SampleValid, MixValid;
    logic [VB-1:0] SampleVoice;
    logic [WD-1:0] Sample;
    logic [WD+VB-1:0] MixOut;

    int checks = 0;
    int errors = 0;

    logic [WD-1:0]    got [NV][$];
    logic [VB-1:0]    vseq[$];
    logic [WD+VB-1:0] mix_q[$];

    wave_gen_poly dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable),
        .CfgWrite(CfgWrite), .CfgVoice(CfgVoice), .CfgIncr(CfgIncr),
        .CfgWaveType(CfgWaveType), .CfgPulseWidth(CfgPulseWidth), .CfgPhaseReset(CfgPhaseReset),
        .SampleValid(SampleValid), .SampleVoice(SampleVoice), .Sample(Sample),
        .MixValid(MixValid), .MixOut(MixOut)
    );

    always #5 Clock = ~Clock;

    task automatic clear_obs();
        for (int v = 0; v < NV; v++) got[v].delete();
        vseq.delete();
        mix_q.delete();
    endtask

    task automatic observe();
        if (SampleValid) begin
            got[SampleVoice].push_back(Sample);
            vseq.push_back(SampleVoice);
        end
        if (MixValid) mix_q.push_back(MixOut);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1; Enable = 1'b0; CfgWrite = 1'b0; CfgPhaseReset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        clear_obs();
    endtask

    task automatic cfg(input int v, input logic [PW-1:0] inc, input logic [1:0] typ,
                       input logic [WD-1:0] pw, input logic prst);
        CfgWrite = 1'b1; CfgVoice = VB'(v); CfgIncr = inc; CfgWaveType = typ;
        CfgPulseWidth = pw; CfgPhaseReset = prst;
        @(negedge Clock);
        CfgWrite = 1'b0; CfgPhaseReset = 1'b0;
    endtask

    // mode 0: Enable held high; mode 1: Enable low every third cycle.
    task automatic run(input int ncyc, input int mode);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clock);
            observe();
            CfgWrite = 1'b0;
            Enable = (mode == 0) ? 1'b1 : ((c % 3) != 2);
        end
        Enable = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Reset = 1'b1; Enable = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if ({SampleValid, SampleVoice, Sample, MixValid, MixOut} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b voice=%0d s=%h mv=%b mix=%h required all 0",
                     SampleValid, SampleVoice, Sample, MixValid, MixOut);
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (SampleValid !== 1'b0) begin
            errors++; $display("FAIL latency_early got SampleValid=%b required 0", SampleValid);
        end
        @(negedge Clock);
        checks++;
        if (SampleValid !== 1'b1 || SampleVoice !== 2'd0 || Sample !== 8'h00) begin
            errors++;
            $display("FAIL latency_first got v=%b voice=%0d s=%h required 1/0/00", SampleValid, SampleVoice, Sample);
        end
        clear_obs();
        run(14, 0);
        checks++;
        if (vseq.size() != 14) begin
            errors++; $display("FAIL idle_count got %0d required 14", vseq.size());
        end else begin
            for (int i = 0; i < 14; i++) begin
                checks++;
                if (vseq[i] !== VB'((i + 1) % 4) || got[vseq[i]].size() == 0) begin
                    errors++; $display("FAIL idle_voice[%0d] got %0d required %0d", i, vseq[i], (i + 1) % 4);
                end
            end
            for (int v = 0; v < NV; v++)
                foreach (got[v][i]) begin
                    checks++;
                    if (got[v][i] !== 8'h00) begin
                        errors++; $display("FAIL idle_sample v%0d[%0d] got %h required 00", v, i, got[v][i]);
                    end
                end
        end
        checks++;
        if (mix_q.size() != 3) begin
            errors++; $display("FAIL idle_mix_count got %0d required 3", mix_q.size());
        end else
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mix_q[i] !== 10'h000) begin
                    errors++; $display("FAIL idle_mix[%0d] got %h required 000", i, mix_q[i]);
                end
            end
    endtask

    task automatic test_saw();
        logic [WD-1:0] exp_s [5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
        do_reset();
        cfg(0, 16'h4000, 2'b00, 8'h80, 1'b1);
        run(24, 0);
        checks++;
        if (got[0].size() < 5) begin
            errors++; $display("FAIL saw_count got %0d required >=5", got[0].size());
        end else
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[0][i] !== exp_s[i]) begin
                    errors++; $display("FAIL saw[%0d] got %h required %h", i, got[0][i], exp_s[i]);
                end
            end
    endtask

    task automatic test_square();
        do_reset();
        cfg(1, 16'h2000, 2'b01, 8'h80, 1'b1);
        run(40, 0);
        checks++;
        if (got[1].size() < 8) begin
            errors++; $display("FAIL square_count got %0d required >=8", got[1].size());
        end else
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[1][i] !== ((i < 4) ? 8'hFF : 8'h00)) begin
                    errors++; $display("FAIL square[%0d] got %h required %h", i, got[1][i], (i < 4) ? 8'hFF : 8'h00);
                end
            end
    endtask

    task automatic test_triangle();
        logic [WD-1:0] exp_t [8] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F};
        do_reset();
        cfg(2, 16'h2000, 2'b10, 8'h80, 1'b1);
        run(40, 0);
        checks++;
        if (got[2].size() < 8) begin
            errors++; $display("FAIL tri_count got %0d required >=8", got[2].size());
        end else
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[2][i] !== exp_t[i]) begin
                    errors++; $display("FAIL tri[%0d] got %h required %h", i, got[2][i], exp_t[i]);
                end
            end
    endtask

    task automatic test_square_bounds();
        logic [WD-1:0] exp_hi [3] = '{8'hFF, 8'h00, 8'hFF};
        do_reset();
        cfg(0, 16'hFF00, 2'b01, 8'hFF, 1'b1);
        cfg(1, 16'h4000, 2'b01, 8'h00, 1'b1);
        run(20, 0);
        checks++;
        if (got[0].size() < 3 || got[1].size() < 3) begin
            errors++; $display("FAIL bounds_count got %0d/%0d required >=3", got[0].size(), got[1].size());
        end else
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[0][i] !== exp_hi[i]) begin
                    errors++; $display("FAIL pw_max[%0d] got %h required %h", i, got[0][i], exp_hi[i]);
                end
                checks++;
                if (got[1][i] !== 8'h00) begin
                    errors++; $display("FAIL pw_zero[%0d] got %h required 00", i, got[1][i]);
                end
            end
    endtask

    task automatic test_mix_stall();
        logic [WD+VB-1:0] exp_m [5] = '{10'h000, 10'h100, 10'h200, 10'h300, 10'h000};
        do_reset();
        for (int v = 0; v < NV; v++) cfg(v, 16'h4000, 2'b00, 8'h80, 1'b1);
        run(60, 1);
        checks++;
        if (mix_q.size() < 5 || vseq.size() < 20) begin
            errors++; $display("FAIL mix_count got %0d mixes %0d samples required >=5/>=20", mix_q.size(), vseq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (mix_q[i] !== exp_m[i]) begin
                    errors++; $display("FAIL mix[%0d] got %h required %h", i, mix_q[i], exp_m[i]);
                end
            end
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (vseq[i] !== VB'(i % 4)) begin
                    errors++; $display("FAIL stall_voice[%0d] got %0d required %0d", i, vseq[i], i % 4);
                end
            end
        end
    endtask

    task automatic test_cfg_collision();
        logic [WD-1:0] exp_c [3] = '{8'h00, 8'h00, 8'h40};
        do_reset();
        Enable = 1'b1;
        CfgWrite = 1'b1; CfgVoice = 2'd0; CfgIncr = 16'h4000; CfgWaveType = 2'b00;
        CfgPulseWidth = 8'h80; CfgPhaseReset = 1'b0;
        run(20, 0);
        checks++;
        if (got[0].size() < 3) begin
            errors++; $display("FAIL collide_count got %0d required >=3", got[0].size());
        end else
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[0][i] !== exp_c[i]) begin
                    errors++; $display("FAIL collide[%0d] got %h required %h", i, got[0][i], exp_c[i]);
                end
            end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        cfg(0, 16'h4000, 2'b00, 8'h80, 1'b1);
        run(7, 0);
        Enable = 1'b1; Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if ({SampleValid, SampleVoice, Sample, MixValid, MixOut} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b voice=%0d s=%h mv=%b mix=%h required all 0",
                     SampleValid, SampleVoice, Sample, MixValid, MixOut);
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (SampleValid !== 1'b0) begin
            errors++; $display("FAIL midreset_drain got SampleValid=%b required 0", SampleValid);
        end
        @(negedge Clock);
        checks++;
        if (SampleValid !== 1'b1 || SampleVoice !== 2'd0 || Sample !== 8'h00) begin
            errors++;
            $display("FAIL midreset_restart got v=%b voice=%0d s=%h required 1/0/00", SampleValid, SampleVoice, Sample);
        end
        clear_obs();
        run(8, 0);
        checks++;
        if (got[0].size() < 2 || got[0][0] !== 8'h00 || got[0][1] !== 8'h00 || vseq.size() < 1 || vseq[0] !== 2'd1) begin
            errors++; $display("FAIL midreset_cfg got %0d voice0 samples, first voice %0d required zeros after voice 1",
                               got[0].size(), (vseq.size() > 0) ? vseq[0] : 0);
        end
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; CfgWrite = 1'b0; CfgPhaseReset = 1'b0;
        CfgVoice = '0; CfgIncr = '0; CfgWaveType = '0; CfgPulseWidth = '0;
        test_reset();
        test_saw();
        test_square();
        test_triangle();
        test_square_bounds();
        test_mix_stall();
        test_cfg_collision();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
